// File: rtl/cla_share_sched.sv
// Time-shares one decomposed CLA (non-linear part + linear part) between NREQ requesters.
// Define CLA_SHARE_RR_EN for round-robin arbitration; otherwise lowest index wins.
module cla_share_sched #(
    parameter int NBIT = 7,
    parameter int NREQ = 2,
    parameter int NNL  = 2**(NBIT+2)-NBIT-4,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*NBIT-1:0] req_a,
    input  logic [NREQ*NBIT-1:0] req_b,
    input  logic [NREQ-1:0]      req_cin,
    output logic [NBIT-1:0]      nl_a,
    output logic [NBIT-1:0]      nl_b,
    output logic                 nl_cin,
    input  logic [NNL-1:0]       nl_n,
    output logic [NNL-1:0]       lin_n,
    input  logic [NBIT:0]        lin_s,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [NBIT:0]        rsp_sum,
    output logic [IDW-1:0]       rsp_id
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_NL   = 2'd1;
    localparam logic [1:0] ST_LIN  = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    logic [1:0]      state;
    logic [IDW-1:0]  id_p0;
    logic            lo_any;
    logic [IDW-1:0]  lo_id;
    logic            grant_any;
    logic [IDW-1:0]  grant_id;
    logic [NREQ-1:0] grant;
    logic [NBIT-1:0] sel_a;
    logic [NBIT-1:0] sel_b;
    logic            sel_cin;

`ifdef CLA_SHARE_RR_EN
    logic [IDW-1:0]  ptr;
    logic            hi_any;
    logic [IDW-1:0]  hi_id;
`endif

    // Descending scan: lo_* ends on the lowest valid index, hi_* on the lowest at/above ptr.
    always_comb begin
        lo_any = 1'b0;
        lo_id  = '0;
`ifdef CLA_SHARE_RR_EN
        hi_any = 1'b0;
        hi_id  = '0;
`endif
        for (int i = NREQ-1; i >= 0; i--) begin
            if (req_valid[i]) begin
                lo_any = 1'b1;
                lo_id  = IDW'(i);
`ifdef CLA_SHARE_RR_EN
                if (IDW'(i) >= ptr) begin
                    hi_any = 1'b1;
                    hi_id  = IDW'(i);
                end
`endif
            end
        end
    end

    assign grant_any = lo_any;
`ifdef CLA_SHARE_RR_EN
    assign grant_id  = hi_any ? hi_id : lo_id;
`else
    assign grant_id  = lo_id;
`endif

    always_comb begin
        grant   = '0;
        sel_a   = '0;
        sel_b   = '0;
        sel_cin = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            grant[i] = grant_any && (grant_id == IDW'(i));
            if (grant[i]) begin
                sel_a   = NBIT'(req_a >> (i*NBIT));
                sel_b   = NBIT'(req_b >> (i*NBIT));
                sel_cin = req_cin[i];
            end
        end
    end

    assign req_ready = (state == ST_IDLE) ? grant : '0;

`ifdef CLA_SHARE_RR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (state == ST_IDLE && grant_any) begin
            ptr <= (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + IDW'(1);
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            nl_a      <= '0;
            nl_b      <= '0;
            nl_cin    <= 1'b0;
            id_p0     <= '0;
            lin_n     <= '0;
            rsp_valid <= 1'b0;
            rsp_sum   <= '0;
            rsp_id    <= '0;
        end else begin
            case (state)
                // Accept: winner's operands feed both adder parts from here on.
                ST_IDLE: begin
                    if (grant_any) begin
                        nl_a   <= sel_a;
                        nl_b   <= sel_b;
                        nl_cin <= sel_cin;
                        id_p0  <= grant_id;
                        state  <= ST_NL;
                    end
                end
                // Register the non-linear terms so the linear part sees a clean stage.
                ST_NL: begin
                    lin_n <= nl_n;
                    state <= ST_LIN;
                end
                // Capture the full NBIT+1 sum including carry out.
                ST_LIN: begin
                    rsp_sum   <= lin_s;
                    rsp_id    <= id_p0;
                    rsp_valid <= 1'b1;
                    state     <= ST_RESP;
                end
                // Hold the response until the consumer takes it.
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cla_share_sched.sv
// Bench for cla_share_sched: behavioural CLA parts attached, directed steps then random traffic
// checked against an arithmetic/queue reference model.
module tb_cla_share_sched;

    localparam int NBIT = 7;
    localparam int NREQ = 2;
    localparam int NNL  = 2**(NBIT+2)-NBIT-4;
    localparam int IDW  = 1;
    localparam int NOPS = 2000;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*NBIT-1:0] req_a;
    logic [NREQ*NBIT-1:0] req_b;
    logic [NREQ-1:0]      req_cin;
    logic [NBIT-1:0]      nl_a;
    logic [NBIT-1:0]      nl_b;
    logic                 nl_cin;
    logic [NNL-1:0]       nl_n;
    logic [NNL-1:0]       lin_n;
    logic [NBIT:0]        lin_s;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [NBIT:0]        rsp_sum;
    logic [IDW-1:0]       rsp_id;

    int checks   = 0;
    int failures = 0;

    logic [NBIT-1:0] opa [NREQ];
    logic [NBIT-1:0] opb [NREQ];
    logic            opc [NREQ];

    cla_share_sched #(.NBIT(NBIT), .NREQ(NREQ)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
        .nl_a(nl_a), .nl_b(nl_b), .nl_cin(nl_cin), .nl_n(nl_n),
        .lin_n(lin_n), .lin_s(lin_s),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_sum(rsp_sum), .rsp_id(rsp_id)
    );

    always #5 clk = ~clk;

    // Non-linear part: carry into every bit plus carry out; linear part: XOR with propagate.
    function automatic logic [NNL-1:0] nl_part(input logic [NBIT-1:0] a, input logic [NBIT-1:0] b,
                                               input logic c);
        logic [NBIT:0] cy;
        cy = '0;
        cy[0] = c;
        for (int i = 0; i < NBIT; i++)
            cy[i+1] = (a[i] & b[i]) | ((a[i] ^ b[i]) & cy[i]);
        nl_part = '0;
        nl_part[NBIT:0] = cy;
    endfunction

    function automatic logic [NBIT:0] lin_part(input logic [NNL-1:0] n, input logic [NBIT-1:0] a,
                                               input logic [NBIT-1:0] b);
        lin_part = '0;
        for (int i = 0; i < NBIT; i++)
            lin_part[i] = a[i] ^ b[i] ^ n[i];
        lin_part[NBIT] = n[NBIT];
    endfunction

    assign nl_n  = nl_part(nl_a, nl_b, nl_cin);
    assign lin_s = lin_part(lin_n, nl_a, nl_b);

    function automatic logic [NBIT:0] add_ref(input logic [NBIT-1:0] a, input logic [NBIT-1:0] b,
                                              input logic c);
        add_ref = {1'b0, a} + {1'b0, b} + {{NBIT{1'b0}}, c};
    endfunction

    // Expected grant: first valid requester at or after the pointer, wrapping.
    function automatic logic [NREQ-1:0] pick(input logic [NREQ-1:0] v, input int p);
        int j;
        pick = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = (p + k) % NREQ;
            if (pick == '0 && ((v >> j) & NREQ'(1)) != '0)
                pick = NREQ'(1) << j;
        end
    endfunction

    function automatic int oh2id(input logic [NREQ-1:0] v);
        oh2id = 0;
        for (int i = 0; i < NREQ; i++)
            if (v[i]) oh2id = i;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive();
        req_a   = '0;
        req_b   = '0;
        req_cin = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_a   = req_a | ((NREQ*NBIT)'(opa[i]) << (i*NBIT));
            req_b   = req_b | ((NREQ*NBIT)'(opb[i]) << (i*NBIT));
            req_cin = req_cin | (NREQ'(opc[i]) << i);
        end
    endtask

    task automatic do_reset();
        req_valid = '0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic run_op(input int r, input logic [NBIT-1:0] a, input logic [NBIT-1:0] b,
                          input logic c, input logic [NBIT:0] exp, input string tag);
        int k;
        opa[r] = a; opb[r] = b; opc[r] = c;
        drive();
        rsp_ready = 1'b1;
        req_valid = NREQ'(1) << r;
        #1;
        k = 0;
        while (req_ready == '0 && k < 8) begin tick(); k++; end
        check({tag, "_ready"}, 32'(req_ready), 32'(NREQ'(1) << r));
        tick();
        req_valid = '0;
        k = 1;
        while (!rsp_valid && k < 10) begin tick(); k++; end
        check({tag, "_latency"}, 32'(k), 32'd3);
        check({tag, "_sum"}, 32'(rsp_sum), 32'(exp));
        check({tag, "_id"}, 32'(rsp_id), 32'(r));
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int exp_ids [4];
    int n, cyc, last_g, done, mptr;
    logic busy, rsp_done;
    logic [NREQ-1:0] exp_rdy, hs;
    logic [NBIT:0] qs [$];
    int qi [$];
    logic [NBIT:0] es;
    int ei;

    initial begin
`ifdef CLA_SHARE_RR_EN
        exp_ids = '{0, 1, 0, 1};
`else
        exp_ids = '{0, 0, 0, 0};
`endif
        for (int i = 0; i < NREQ; i++) begin opa[i] = '0; opb[i] = '0; opc[i] = 1'b0; end
        drive();
        rst_n = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        tick();
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_nl_a", 32'(nl_a), 32'd0);
        check("rst_nl_b", 32'(nl_b), 32'd0);
        check("rst_nl_cin", 32'(nl_cin), 32'd0);
        check("rst_lin_n", 32'(|lin_n), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_sum", 32'(rsp_sum), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single operation with cycle-by-cycle latency.
        opa[0] = 7'h7F; opb[0] = 7'h01; opc[0] = 1'b0;
        drive();
        req_valid = 2'b01;
        #1;
        check("t1_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        check("t1_nl_a", 32'(nl_a), 32'h7F);
        check("t1_busy_ready", 32'(req_ready), 32'd0);
        check("t1_c1_valid", 32'(rsp_valid), 32'd0);
        tick();
        check("t1_c2_valid", 32'(rsp_valid), 32'd0);
        tick();
        check("t1_c3_valid", 32'(rsp_valid), 32'd1);
        check("t1_sum", 32'(rsp_sum), 32'h80);
        check("t1_id", 32'(rsp_id), 32'd0);
        tick();
        check("t1_drop", 32'(rsp_valid), 32'd0);

        // Both requesters valid every cycle.
        do_reset();
        opa[0] = 7'h11; opb[0] = 7'h22; opc[0] = 1'b0;
        opa[1] = 7'h40; opb[1] = 7'h45; opc[1] = 1'b1;
        drive();
        rsp_ready = 1'b1;
        req_valid = 2'b11;
        #1;
        n = 0; cyc = 0; last_g = -1;
        while (n < 4 && cyc < 40) begin
            if (req_ready != '0) begin
                if (last_g >= 0) check("t2_gap", 32'(cyc - last_g), 32'd4);
                last_g = cyc;
            end
            tick();
            cyc++;
            if (rsp_valid) begin
                check("t2_id", 32'(rsp_id), 32'(exp_ids[n]));
                check("t2_sum", 32'(rsp_sum),
                      32'(add_ref(opa[exp_ids[n]], opb[exp_ids[n]], opc[exp_ids[n]])));
                n++;
            end
        end
        check("t2_count", 32'(n), 32'd4);
        req_valid = '0;
        tick();
        tick();

        // Backpressure on the response side.
        do_reset();
        opa[0] = 7'h03; opb[0] = 7'h04; opc[0] = 1'b0;
        opa[1] = 7'h2A; opb[1] = 7'h15; opc[1] = 1'b1;
        drive();
        rsp_ready = 1'b0;
        req_valid = 2'b10;
        #1;
        check("t3_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = 2'b11;
        tick();
        tick();
        check("t3_valid", 32'(rsp_valid), 32'd1);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t3_hold_valid", 32'(rsp_valid), 32'd1);
            check("t3_hold_sum", 32'(rsp_sum), 32'h40);
            check("t3_hold_id", 32'(rsp_id), 32'd1);
            check("t3_hold_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        tick();
        check("t3_drop", 32'(rsp_valid), 32'd0);
        check("t3_regrant", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        check("t3_next_nl_a", 32'(nl_a), 32'h03);
        tick();
        tick();
        check("t3_next_sum", 32'(rsp_sum), 32'h07);
        tick();

        // Carry paths.
        run_op(0, 7'h7F, 7'h7F, 1'b1, 8'hFF, "t4_max");
        run_op(1, 7'h00, 7'h00, 1'b1, 8'h01, "t4_cin");
        run_op(0, 7'h00, 7'h00, 1'b0, 8'h00, "t4_zero");

        // Reset while in the NL state.
        opa[0] = 7'h33; opb[0] = 7'h44; opc[0] = 1'b1;
        drive();
        req_valid = 2'b01;
        tick();
        req_valid = '0;
        rst_n = 1'b0;
        #1;
        check("t5_rsp_valid", 32'(rsp_valid), 32'd0);
        check("t5_req_ready", 32'(req_ready), 32'd0);
        check("t5_nl_a", 32'(nl_a), 32'd0);
        check("t5_nl_b", 32'(nl_b), 32'd0);
        check("t5_nl_cin", 32'(nl_cin), 32'd0);
        check("t5_lin_n", 32'(|lin_n), 32'd0);
        check("t5_rsp_sum", 32'(rsp_sum), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("t5_no_rsp", 32'(rsp_valid), 32'd0);
        end
        run_op(1, 7'h5A, 7'h25, 1'b0, 8'h7F, "t5_fresh");

        // Random traffic against the reference model.
        do_reset();
        mptr = 0; busy = 1'b0; done = 0; cyc = 0;
        while (done < NOPS && cyc < 60000) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        opa[i] = 7'($urandom);
                        opb[i] = 7'($urandom);
                        opc[i] = 1'($urandom);
                        req_valid[i] = 1'b1;
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            drive();
            #1;
            exp_rdy = busy ? '0 : pick(req_valid, mptr);
            check("rnd_ready", 32'(req_ready), 32'(exp_rdy));
            hs = exp_rdy & req_valid;
            rsp_done = 1'b0;
            if (rsp_valid && rsp_ready) begin
                rsp_done = 1'b1;
                if (qs.size() == 0) begin
                    check("rnd_extra_rsp", 32'(rsp_valid), 32'd0);
                end else begin
                    es = qs.pop_front();
                    ei = qi.pop_front();
                    check("rnd_sum", 32'(rsp_sum), 32'(es));
                    check("rnd_id", 32'(rsp_id), 32'(ei));
                    done++;
                end
            end
            if (hs != '0) begin
                ei = oh2id(hs);
                qs.push_back(add_ref(opa[ei], opb[ei], opc[ei]));
                qi.push_back(ei);
                busy = 1'b1;
`ifdef CLA_SHARE_RR_EN
                mptr = (ei + 1) % NREQ;
`endif
            end
            tick();
            cyc++;
            if (rsp_done) busy = 1'b0;
            req_valid = req_valid & ~hs;
        end
        check("rnd_done", 32'(done), 32'(NOPS));
        req_valid = '0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
